run_length_encoder: RTL and testbench
=====================================

# run_length_encoder

Downstream consumer of the five-state Moore detector's 1-bit `data_out` stream. It compresses the bit stream into (bit value, run length) records and buffers them in a 2-entry output queue with valid/ready handshakes on both sides. Records feed the status/trace logic that follows the detector.

## Interface
- `CNT_W`, default 8: run-length counter and `out_len` width. MAX = 2^CNT_W − 1.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset (sampled on `clock` rising edge).
- `in_valid`  in  1  upstream has a bit on `in_bit`.
- `in_bit`  in  1  stream bit (detector `data_out`).
- `in_ready`  out  1  block can accept a bit this cycle.
- `flush`  in  1  level request to close the open run.
- `out_valid`  out  1  queue head holds a record.
- `out_bit`  out  1  bit value of head record.
- `out_len`  out  CNT_W  run length of head record, 1..MAX.
- `out_ready`  in  1  downstream takes head record.
- `idle`  out  1  no open run and queue empty.

## Operation
- Accept = `in_valid && in_ready`. Pop = `out_valid && out_ready`.
- `in_ready` = (queue count < 2) && !`flush`, from registered count only; no same-cycle pop pass-through. Flush and accept never coincide.
- FSM states:
  - EMPTY: no open run.
  - OPEN: run register holds `cur_bit`, `cur_len` (1..MAX).
- EMPTY + accept → OPEN, `cur_bit`=`in_bit`, `cur_len`=1, nothing pushed.
- OPEN + accept:
  - `in_bit`==`cur_bit`, `cur_len`<MAX → `cur_len`+1.
  - `in_bit`==`cur_bit`, `cur_len`==MAX → push (`cur_bit`, MAX), `cur_len`=1, stay OPEN.
  - `in_bit`!=`cur_bit` → push (`cur_bit`, `cur_len`), `cur_bit`=`in_bit`, `cur_len`=1.
- Flush:
  - OPEN + `flush` + count<2 → push (`cur_bit`, `cur_len`), go EMPTY.
  - OPEN + count==2 → flush has no effect; upstream holds `flush` until taken.
  - EMPTY + `flush` → no effect.
- At most one push per cycle. Push only occurs when count<2, guaranteed by `in_ready` and the flush rule.
- Queue: 2-entry FIFO, oldest record at head. Push and pop in the same cycle is legal at count 1 or 2 and leaves count unchanged. Pop at count 0 is impossible because `out_valid` is 0.
- `idle` = state EMPTY && count==0.
- Head fields are stable while `out_valid` && !`out_ready`.
- Reset (`reset`==0 at an edge) clears state to EMPTY, count to 0, run register to 0, discarding any open run and queued records. While `reset` is low, `in_ready` is forced 0.

## Timing
- Reset values:
  - `out_valid`=0, `out_bit`=0, `out_len`=0, `idle`=1.
  - `in_ready`=0 while `reset` low; 1 on the first cycle after release, provided `flush` is low.
- Record closed by an accept or flush at edge k has `out_valid`=1 from edge k (visible the cycle after the closing input).
- Throughput: 1 bit/cycle while the downstream pops at least as fast as runs close.
- Queue full: `in_ready`=0 for the cycle after the push that fills it. Input resumes the cycle after the first pop.
- Reset mid-run: open run lost, no record emitted. Reset mid-handshake: `out_valid` drops at the reset edge.

## Structure
- Package `rle_pkg`:
  - state enum (EMPTY, OPEN);
  - record struct {bit, len};
  - default CNT_W;
  - function returning MAX for a given width.
- Sub-module `rle_fifo2`: 2-entry synchronous FIFO of records with count, full/empty, simultaneous push/pop, same reset.
- Top holds the FSM, run register and compare/saturate logic.

## Test plan
All scenarios use CNT_W=4 (MAX=15).
- Reset then stream 1,1,1,0,0, flush, `out_ready`=1 → records (1,3), (0,2); `idle`=1 afterwards. Mid-stream reset → `out_valid`=0, `idle`=1, `in_ready` back to 1 the cycle after release.
- Stream 17 consecutive 1s then flush → records (1,15), (1,2).
- `out_ready`=0, alternate 0,1,0,1 → two records queued, `in_ready`=0 after 3rd accept. Set `out_ready`=1 → drains (0,1), (1,1); `in_ready` returns 1 the cycle after the first pop.
- Count 2 with `flush` held 3 cycles, `out_ready` raised at cycle 2 → flush taken at cycle 3 (first cycle count<2), exactly one extra record, `in_ready`=0 throughout `flush`.
- Count 1 with simultaneous push and pop → count stays 1; head updates to the new record next cycle; no record lost or duplicated.

Source files
------------

// File: rtl/run_length_encoder_pkg.sv
// Shared types and helpers for the run-length encoder: FSM state, queued record
// and the saturation limit for a given counter width.
package rle_pkg;

    localparam int RLE_CNT_W_DEFAULT = 8;
    // Widest run length a record can carry; CNT_W must not exceed this.
    localparam int RLE_LEN_W         = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        OPEN  = 1'b1
    } rle_state_t;

    typedef struct packed {
        logic                 value;
        logic [RLE_LEN_W-1:0] len;
    } rle_rec_t;

    function automatic int unsigned rle_max_len(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/run_length_encoder_if.sv
// Bit-stream input and record-output handshakes of the run-length encoder.
interface run_length_encoder_if
    import rle_pkg::*;
#(
    parameter int CNT_W = RLE_CNT_W_DEFAULT
);
    logic             in_valid;
    logic             in_bit;
    logic             in_ready;
    logic             flush;
    logic             out_valid;
    logic             out_bit;
    logic [CNT_W-1:0] out_len;
    logic             out_ready;

    modport master (
        output in_valid, in_bit, flush, out_ready,
        input  in_ready, out_valid, out_bit, out_len
    );

    modport slave (
        input  in_valid, in_bit, flush, out_ready,
        output in_ready, out_valid, out_bit, out_len
    );
endinterface

// File: rtl/rle_fifo2.sv
// Two-entry record FIFO; push and pop may coincide whenever an entry is present.
module rle_fifo2
    import rle_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  rle_rec_t   push_rec,
    input  logic       pop,
    output rle_rec_t   head,
    output logic [1:0] count,
    output logic       full,
    output logic       empty
);
    rle_rec_t   mem_reg [2];
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clock) begin
            if (!reset) begin
                mem_reg[gi] <= '0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
                mem_reg[gi] <= push_rec;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;
    assign full  = (count_reg == 2'd2);
    assign empty = (count_reg == 2'd0);
endmodule

// File: rtl/run_length_encoder.sv
// Compresses a 1-bit stream into (value, length) records, saturating runs at
// MAX, and queues them in a two-entry FIFO.
module run_length_encoder
    import rle_pkg::*;
#(
    parameter int CNT_W = RLE_CNT_W_DEFAULT
)(
    input  logic                 clock,
    input  logic                 reset,
    run_length_encoder_if.slave  bus,
    output logic                 idle
);
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(rle_max_len(CNT_W));

    rle_state_t       state_reg, state_next;
    logic             cur_bit_reg, cur_bit_next;
    logic [CNT_W-1:0] cur_len_reg, cur_len_next;

    logic       push, pop, accept;
    logic       fifo_full, fifo_empty;
    logic [1:0] fifo_count;
    rle_rec_t   push_rec, head_rec;

    // Ready depends only on the registered fill level, never on a same-cycle pop.
    assign bus.in_ready = reset && !fifo_full && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign pop          = bus.out_valid && bus.out_ready;
    assign push_rec     = '{value: cur_bit_reg, len: RLE_LEN_W'(cur_len_reg)};

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg   <= EMPTY;
            cur_bit_reg <= 1'b0;
            cur_len_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cur_bit_reg <= cur_bit_next;
            cur_len_reg <= cur_len_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cur_bit_next = cur_bit_reg;
        cur_len_next = cur_len_reg;
        push         = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    state_next   = OPEN;
                    cur_bit_next = bus.in_bit;
                    cur_len_next = CNT_W'(1);
                end
            end
            OPEN: begin
                if (accept) begin
                    if (bus.in_bit == cur_bit_reg && cur_len_reg < MAX_LEN) begin
                        cur_len_next = cur_len_reg + 1'b1;
                    end else begin
                        // Saturated run or bit change: close the run, open a new one.
                        push         = 1'b1;
                        cur_bit_next = bus.in_bit;
                        cur_len_next = CNT_W'(1);
                    end
                end else if (bus.flush && !fifo_full) begin
                    push       = 1'b1;
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    rle_fifo2 u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_rec (push_rec),
        .pop      (pop),
        .head     (head_rec),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    wire unused_head_bits = ^{head_rec.len, fifo_count};

    assign bus.out_valid = !fifo_empty;
    assign bus.out_bit   = head_rec.value;
    assign bus.out_len   = head_rec.len[CNT_W-1:0];
    assign idle          = (state_reg == EMPTY) && fifo_empty;
endmodule

// File: tb/tb_run_length_encoder.sv
// Randomized and directed checks of run_length_encoder against a queue-based
// model of runs and queued records.
module tb_run_length_encoder;
    import rle_pkg::*;

    localparam int W   = 4;
    localparam int MAX = 15;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic idle;

    run_length_encoder_if #(.CNT_W(W)) bus ();

    run_length_encoder #(.CNT_W(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave),
        .idle  (idle)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit v;
        int len;
    } rec_s;

    int   checks = 0;
    int   errors = 0;
    bit   pend_q[$];
    rec_s exp_q[$];
    rec_s got_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input bit b, input bit f, input bit r);
        bus.in_valid  = v;
        bus.in_bit    = b;
        bus.flush     = f;
        bus.out_ready = r;
    endtask

    function automatic void emit();
        rec_s r;
        r.v   = pend_q[0];
        r.len = pend_q.size();
        exp_q.push_back(r);
        pend_q.delete();
    endfunction

    // One clock cycle: check ready, advance the model across the edge, check outputs.
    task automatic step();
        bit   m_ready, acc, pop, flush_take;
        rec_s seen;
        #1;
        m_ready    = reset && (exp_q.size() < 2) && !bus.flush;
        check("in_ready", bus.in_ready, m_ready);
        acc        = bus.in_valid && m_ready;
        pop        = reset && (exp_q.size() > 0) && bus.out_ready;
        flush_take = reset && bus.flush && (exp_q.size() < 2) && (pend_q.size() > 0);
        seen.v     = bus.out_bit;
        seen.len   = int'(bus.out_len);
        @(posedge clock);
        if (!reset) begin
            pend_q.delete();
            exp_q.delete();
        end else begin
            if (pop) begin
                exp_q.pop_front();
                got_q.push_back(seen);
                $display("pop bit=%0d len=%0d t=%0t", seen.v, seen.len, $time);
            end
            if (acc) begin
                if (pend_q.size() > 0 && (pend_q[0] != bus.in_bit || pend_q.size() == MAX))
                    emit();
                pend_q.push_back(bus.in_bit);
            end else if (flush_take) begin
                emit();
            end
        end
        #1;
        check("out_valid", bus.out_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            check("out_bit", bus.out_bit, exp_q[0].v);
            check("out_len", bus.out_len, exp_q[0].len);
        end
        check("idle", idle, (pend_q.size() == 0) && (exp_q.size() == 0));
    endtask

    task automatic feed(input bit b, input bit r);
        int guard = 0;
        bit taken = 0;
        while (!taken && guard < 40) begin
            drive(1, b, 0, r);
            #1;
            taken = bus.in_ready;
            step();
            guard++;
        end
        if (!taken) check("feed_timeout", 0, 1);
        drive(0, 0, 0, r);
    endtask

    task automatic flush_until_taken(input bit r);
        int guard = 0;
        while (pend_q.size() > 0 && guard < 40) begin
            drive(0, 0, 1, r);
            step();
            guard++;
        end
        if (pend_q.size() > 0) check("flush_timeout", 0, 1);
        drive(0, 0, 0, r);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1);
            step();
        end
    endtask

    task automatic check_rec(input int idx, input bit v, input int len);
        if (idx < got_q.size()) begin
            check("rec_bit", got_q[idx].v, v);
            check("rec_len", got_q[idx].len, len);
        end else begin
            check("rec_missing", got_q.size(), idx + 1);
        end
    endtask

    initial begin
        drive(0, 0, 0, 1);
        reset = 1'b0;
        step();
        step();
        check("rst_out_bit", bus.out_bit, 0);
        check("rst_out_len", bus.out_len, 0);
        check("rst_in_ready", bus.in_ready, 0);
        reset = 1'b1;

        // 1,1,1,0,0 then flush
        got_q.delete();
        feed(1, 1); feed(1, 1); feed(1, 1); feed(0, 1); feed(0, 1);
        flush_until_taken(1);
        drain();
        check("s1_count", got_q.size(), 2);
        check_rec(0, 1, 3);
        check_rec(1, 0, 2);

        // Mid-stream reset discards the open run
        feed(1, 1); feed(1, 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        drive(0, 0, 0, 1);
        step();
        check("post_rst_in_ready", bus.in_ready, 1);

        // Saturation: 17 ones
        got_q.delete();
        for (int i = 0; i < 17; i++) feed(1, 1);
        flush_until_taken(1);
        drain();
        check("s2_count", got_q.size(), 2);
        check_rec(0, 1, 15);
        check_rec(1, 1, 2);

        // Backpressure: alternate with out_ready low, then drain
        got_q.delete();
        feed(0, 0); feed(1, 0); feed(0, 0);
        drive(1, 1, 0, 0);
        step();
        check("full_in_ready", bus.in_ready, 0);
        feed(1, 1);
        flush_until_taken(1);
        drain();
        check("s3_count", got_q.size(), 4);
        check_rec(0, 0, 1);
        check_rec(1, 1, 1);
        check_rec(2, 0, 1);
        check_rec(3, 1, 1);

        // Flush held at count 2, downstream ready from the second cycle
        got_q.delete();
        feed(1, 0); feed(0, 0); feed(1, 0);
        drive(0, 0, 1, 0);
        step();
        drive(0, 0, 1, 1);
        step();
        flush_until_taken(1);
        drain();
        check("s4_count", got_q.size(), 3);
        check_rec(2, 1, 1);

        // Push and pop together at count 1
        got_q.delete();
        for (int i = 0; i < 6; i++) feed(i[0], 1);
        flush_until_taken(1);
        drain();
        check("s5_count", got_q.size(), 6);

        // Random traffic with runs, flushes, backpressure and rare resets
        begin
            bit b = 0;
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(3) == 0) b = ~b;
                reset = ($urandom_range(199) != 0);
                drive($urandom_range(3) != 0, b, $urandom_range(15) == 0,
                      $urandom_range(3) != 0);
                step();
            end
            reset = 1'b1;
            flush_until_taken(1);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
